// File: rtl/eth_pkg.sv
// Shared Ethernet RX definitions: header geometry, broadcast address, parser states.
package eth_pkg;

    localparam int unsigned ETH_HDR_BYTES = 14;
    // Byte lane of input word 1 that holds the first payload byte.
    localparam int unsigned HDR_TAIL_LANE = ETH_HDR_BYTES - 8;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        StHdr0,
        StHdr1,
        StPayload,
        StFlush,
        StDrop
    } rx_state_e;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] ether_type;
    } eth_hdr_t;

endpackage

// File: rtl/axis_realign_reg.sv
// Output stage: merges the two held tail bytes of the previous input word with
// bytes 0-5 of the current one and registers the result with tkeep/tlast.
module axis_realign_reg
    import eth_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [47:0] word_data,
    input  logic [6:0]  word_keep,
    input  logic        word_last,
    input  logic [15:0] hold_data,
    input  logic [1:0]  hold_keep,
    output logic        ready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
);

    logic        valid_q;
    logic [63:0] data_q, data_d;
    logic [7:0]  keep_q, keep_d;
    logic        last_q, last_d;

    assign ready         = !valid_q || m_axis_tready;
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = valid_q;

    // Build the next output word: realigned full word, short final word, or flush tail.
    always_comb begin
        data_d = {word_data, hold_data};
        keep_d = 8'hFF;
        last_d = 1'b0;
        if (flush) begin
            data_d = {48'b0, hold_data};
            // Flush only follows a word whose lane 6 was valid, so this is 0x01 or 0x03.
            keep_d = {6'b0, hold_keep};
            last_d = 1'b1;
        end else if (word_last && !word_keep[HDR_TAIL_LANE]) begin
            keep_d = {word_keep[5:0], 2'b11};
            last_d = 1'b1;
        end
    end

    // Single output register; data only changes when a new word is loaded.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end else if (m_axis_tready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ethernet_header_remover.sv
// Strips the 14-byte Ethernet header from 64-bit AXI-Stream frames, publishes the
// header on a single-entry metadata handshake and forwards the realigned payload.
module ethernet_header_remover
    import eth_pkg::*;
#(
    parameter bit          FILTER_EN = 1'b1,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [47:0]          my_mac,
    input  logic [63:0]          s_axis_tdata,
    input  logic [7:0]           s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic [7:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [47:0]          m_meta_dst,
    output logic [47:0]          m_meta_src,
    output logic [15:0]          m_meta_type,
    output logic                 m_meta_valid,
    input  logic                 m_meta_ready,
    output logic [CNT_WIDTH-1:0] cnt_ok,
    output logic [CNT_WIDTH-1:0] cnt_filtered,
    output logic [CNT_WIDTH-1:0] cnt_runt
);

    rx_state_e state_q, state_d;

    logic [47:0]          dst_q;
    logic [15:0]          src_lo_q;
    logic                 dst_match_q;
    logic [15:0]          hold_data_q;
    logic [1:0]           hold_keep_q;
    eth_hdr_t             meta_q;
    logic                 meta_valid_q;
    logic [CNT_WIDTH-1:0] cnt_ok_q, cnt_filtered_q, cnt_runt_q;

    logic out_ready;
    logic s_ready;
    logic capture_hdr, hold_en, meta_load, out_load, out_flush;
    logic ok_inc, runt_inc, filt_inc;
    logic dst_match;

    assign dst_match = !FILTER_EN || (s_axis_tdata[47:0] == my_mac) ||
                       (s_axis_tdata[47:0] == BROADCAST_MAC);

    assign s_axis_tready = s_ready;
    assign m_meta_dst    = meta_q.dst;
    assign m_meta_src    = meta_q.src;
    assign m_meta_type   = meta_q.ether_type;
    assign m_meta_valid  = meta_valid_q;
    assign cnt_ok        = cnt_ok_q;
    assign cnt_filtered  = cnt_filtered_q;
    assign cnt_runt      = cnt_runt_q;

    // Parser state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StHdr0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, input ready and per-beat control strobes.
    always_comb begin
        state_d     = state_q;
        s_ready     = 1'b0;
        capture_hdr = 1'b0;
        hold_en     = 1'b0;
        meta_load   = 1'b0;
        out_load    = 1'b0;
        out_flush   = 1'b0;
        ok_inc      = 1'b0;
        runt_inc    = 1'b0;
        filt_inc    = 1'b0;
        unique case (state_q)
            StHdr0: begin
                s_ready = out_ready;
                if (s_axis_tvalid && s_ready) begin
                    if (s_axis_tlast) begin
                        runt_inc = 1'b1;
                    end else begin
                        capture_hdr = 1'b1;
                        state_d     = StHdr1;
                    end
                end
            end
            StHdr1: begin
                // Never overwrite metadata the consumer has not taken yet.
                s_ready = out_ready && !(meta_valid_q && !m_meta_ready);
                if (s_axis_tvalid && s_ready) begin
                    if (s_axis_tlast && !s_axis_tkeep[HDR_TAIL_LANE]) begin
                        runt_inc = 1'b1;
                        state_d  = StHdr0;
                    end else if (!dst_match_q) begin
                        filt_inc = 1'b1;
                        state_d  = s_axis_tlast ? StHdr0 : StDrop;
                    end else begin
                        meta_load = 1'b1;
                        hold_en   = 1'b1;
                        state_d   = s_axis_tlast ? StFlush : StPayload;
                    end
                end
            end
            StPayload: begin
                s_ready = out_ready;
                if (s_axis_tvalid && s_ready) begin
                    out_load = 1'b1;
                    hold_en  = 1'b1;
                    if (s_axis_tlast) begin
                        if (s_axis_tkeep[HDR_TAIL_LANE]) begin
                            state_d = StFlush;
                        end else begin
                            ok_inc  = 1'b1;
                            state_d = StHdr0;
                        end
                    end
                end
            end
            StFlush: begin
                if (out_ready) begin
                    out_load  = 1'b1;
                    out_flush = 1'b1;
                    ok_inc    = 1'b1;
                    state_d   = StHdr0;
                end
            end
            StDrop: begin
                s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = StHdr0;
                end
            end
            default: state_d = StHdr0;
        endcase
    end

    // Header capture, tail-byte hold and the metadata entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            dst_q        <= '0;
            src_lo_q     <= '0;
            dst_match_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_keep_q  <= '0;
            meta_q       <= '0;
            meta_valid_q <= 1'b0;
        end else begin
            if (capture_hdr) begin
                dst_q       <= s_axis_tdata[47:0];
                src_lo_q    <= s_axis_tdata[63:48];
                dst_match_q <= dst_match;
            end
            if (hold_en) begin
                hold_data_q <= s_axis_tdata[63:48];
                hold_keep_q <= s_axis_tkeep[7:6];
            end
            if (meta_load) begin
                meta_q.dst        <= dst_q;
                meta_q.src        <= {s_axis_tdata[31:0], src_lo_q};
                meta_q.ether_type <= {s_axis_tdata[39:32], s_axis_tdata[47:40]};
                meta_valid_q      <= 1'b1;
            end else if (m_meta_ready) begin
                meta_valid_q <= 1'b0;
            end
        end
    end

    // Wrapping frame statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_ok_q       <= '0;
            cnt_filtered_q <= '0;
            cnt_runt_q     <= '0;
        end else begin
            if (ok_inc)   cnt_ok_q       <= cnt_ok_q + CNT_WIDTH'(1);
            if (filt_inc) cnt_filtered_q <= cnt_filtered_q + CNT_WIDTH'(1);
            if (runt_inc) cnt_runt_q     <= cnt_runt_q + CNT_WIDTH'(1);
        end
    end

    axis_realign_reg u_realign (
        .clock         (clock),
        .reset         (reset),
        .load          (out_load),
        .flush         (out_flush),
        .word_data     (s_axis_tdata[47:0]),
        .word_keep     (s_axis_tkeep[6:0]),
        .word_last     (s_axis_tlast),
        .hold_data     (hold_data_q),
        .hold_keep     (hold_keep_q),
        .ready         (out_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_ethernet_header_remover.sv
// Bench for ethernet_header_remover: directed vector table, hand-written corner
// sequences and randomized frames checked against a byte-level frame model.
module tb_ethernet_header_remover;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
    } meta_t;
    typedef struct {
        int         len;
        int         kind;
        int         words;
        logic [7:0] last_keep;
        int         d_ok;
        int         d_runt;
        int         d_filt;
    } vec_t;

    localparam logic [47:0] MY_MAC    = 48'h01_00_00_00_00_02;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER_MAC = 48'h99_00_00_00_00_02;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [47:0] m_meta_dst;
    logic [47:0] m_meta_src;
    logic [15:0] m_meta_type;
    logic        m_meta_valid;
    logic        m_meta_ready = 1'b1;
    logic [31:0] cnt_ok, cnt_filtered, cnt_runt;

    always #5 clock = ~clock;

    ethernet_header_remover #(
        .FILTER_EN (1'b1),
        .CNT_WIDTH (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .my_mac        (MY_MAC),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_meta_dst    (m_meta_dst),
        .m_meta_src    (m_meta_src),
        .m_meta_type   (m_meta_type),
        .m_meta_valid  (m_meta_valid),
        .m_meta_ready  (m_meta_ready),
        .cnt_ok        (cnt_ok),
        .cnt_filtered  (cnt_filtered),
        .cnt_runt      (cnt_runt)
    );

    int         checks = 0;
    int         errors = 0;
    bq_t        got_bytes, exp_bytes;
    int         got_lens[$], exp_lens[$];
    meta_t      got_meta[$], exp_meta[$];
    int         cur_len = 0;
    int         obs_words = 0;
    logic [7:0] obs_last_keep = '0;
    bit         rnd = 1'b0;
    bit         count_low = 1'b0;
    int         lowcnt = 0;
    bit         abort = 1'b0;
    bit         done = 1'b0;
    int         ok_e = 0, runt_e = 0, filt_e = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s got=timeout exp=completion", name);
    endtask

    // Observe both handshakes between edges; inputs only change just after posedge.
    always @(negedge clock) begin
        if (!reset) begin
            if (m_axis_tvalid && m_axis_tready) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_axis_tkeep[i]) begin
                        got_bytes.push_back(m_axis_tdata[8*i +: 8]);
                        cur_len++;
                    end
                end
                obs_words++;
                if (m_axis_tlast) begin
                    got_lens.push_back(cur_len);
                    cur_len = 0;
                    obs_last_keep = m_axis_tkeep;
                end
            end
            if (m_meta_valid && m_meta_ready)
                got_meta.push_back(meta_t'({m_meta_dst, m_meta_src, m_meta_type}));
            if (count_low && !s_axis_tready) lowcnt++;
        end
    end

    always @(posedge clock) begin
        #1;
        if (rnd) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            m_meta_ready  = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    function automatic bq_t make_frame(input int len, input int kind);
        bq_t         f;
        logic [47:0] dst;
        dst = (kind == 0) ? MY_MAC : (kind == 1) ? BCAST : OTHER_MAC;
        for (int i = 0; i < len; i++) begin
            if (i < 6) f.push_back(dst[8*i +: 8]);
            else       f.push_back(8'($urandom));
        end
        return f;
    endfunction

    // Byte-level reference: 0 = forwarded, 1 = runt, 2 = filtered.
    function automatic int model_frame(input bq_t f);
        logic [47:0] dst;
        meta_t       m;
        if (f.size() <= 14) return 1;
        for (int i = 0; i < 6; i++) dst[8*i +: 8] = f[i];
        if (dst != MY_MAC && dst != BCAST) return 2;
        for (int i = 0; i < 6; i++) begin
            m.dst[8*i +: 8] = f[i];
            m.src[8*i +: 8] = f[6+i];
        end
        m.typ = {f[12], f[13]};
        exp_meta.push_back(m);
        for (int i = 14; i < f.size(); i++) exp_bytes.push_back(f[i]);
        exp_lens.push_back(f.size() - 14);
        return 0;
    endfunction

    task automatic tally(input int c);
        if (c == 0) ok_e++;
        else if (c == 1) runt_e++;
        else filt_e++;
    endtask

    // Called just after a posedge; returns just after the posedge that took the word.
    task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        n = 0;
        if (abort) return;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clock);
            if (s_axis_tready) break;
            n++;
            if (n > 3000) begin
                bound_fail("input handshake");
                abort = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic word_of(input bq_t f, input int w, output logic [63:0] d,
                           output logic [7:0] k);
        d = '0;
        k = '0;
        for (int b = 0; b < 8; b++) begin
            if (8*w + b < f.size()) begin
                d[8*b +: 8] = f[8*w + b];
                k[b] = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input bq_t f);
        int          nw;
        logic [63:0] d;
        logic [7:0]  k;
        nw = (f.size() + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            word_of(f, w, d, k);
            send_word(d, k, w == nw - 1);
        end
    endtask

    task automatic drain();
        int quiet, n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < 20000) begin
            @(negedge clock);
            n++;
            if (!m_axis_tvalid && !m_meta_valid) quiet++;
            else quiet = 0;
        end
        @(posedge clock);
        #1;
        if (quiet < 4) bound_fail("output drain");
    endtask

    task automatic clear_queues();
        got_bytes.delete();
        exp_bytes.delete();
        got_lens.delete();
        exp_lens.delete();
        got_meta.delete();
        exp_meta.delete();
        cur_len = 0;
    endtask

    task automatic compare_streams(input string tag);
        int bad, n;
        bad = 0;
        check({tag, " byte count"}, got_bytes.size(), exp_bytes.size());
        check({tag, " frame count"}, got_lens.size(), exp_lens.size());
        check({tag, " meta count"}, got_meta.size(), exp_meta.size());
        n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
        for (int i = 0; i < n; i++) if (got_bytes[i] !== exp_bytes[i]) bad++;
        n = (got_lens.size() < exp_lens.size()) ? got_lens.size() : exp_lens.size();
        for (int i = 0; i < n; i++) if (got_lens[i] != exp_lens[i]) bad++;
        n = (got_meta.size() < exp_meta.size()) ? got_meta.size() : exp_meta.size();
        for (int i = 0; i < n; i++) if (got_meta[i] !== exp_meta[i]) bad++;
        check({tag, " content mismatches"}, bad, 0);
        clear_queues();
    endtask

    task automatic check_counters(input string tag);
        check({tag, " cnt_ok"}, cnt_ok, ok_e);
        check({tag, " cnt_runt"}, cnt_runt, runt_e);
        check({tag, " cnt_filtered"}, cnt_filtered, filt_e);
    endtask

    initial begin
        vec_t        tab[13];
        bq_t         f, fa, fb;
        logic [63:0] d;
        logic [7:0]  k;
        int          n;

        // len, dst kind (0 mine, 1 bcast, 2 other), words, last tkeep, d_ok, d_runt, d_filt
        tab[0]  = '{60, 0, 6, 8'h3F, 1, 0, 0};
        tab[1]  = '{64, 0, 7, 8'h03, 1, 0, 0};
        tab[2]  = '{14, 0, 0, 8'h00, 0, 1, 0};
        tab[3]  = '{8,  0, 0, 8'h00, 0, 1, 0};
        tab[4]  = '{15, 0, 1, 8'h01, 1, 0, 0};
        tab[5]  = '{60, 2, 0, 8'h00, 0, 0, 1};
        tab[6]  = '{60, 1, 6, 8'h3F, 1, 0, 0};
        tab[7]  = '{16, 0, 1, 8'h03, 1, 0, 0};
        tab[8]  = '{17, 0, 1, 8'h07, 1, 0, 0};
        tab[9]  = '{22, 0, 1, 8'hFF, 1, 0, 0};
        tab[10] = '{23, 0, 2, 8'h01, 1, 0, 0};
        tab[11] = '{24, 0, 2, 8'h03, 1, 0, 0};
        tab[12] = '{9,  2, 0, 8'h00, 0, 1, 0};

        repeat (4) @(posedge clock);
        #1;
        check("reset m_axis_tvalid", m_axis_tvalid, 0);
        check("reset m_meta_valid", m_meta_valid, 0);
        check("reset m_axis_tdata", m_axis_tdata, 0);
        check("reset m_meta_dst", m_meta_dst, 0);
        check_counters("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 13; i++) begin
            obs_words = 0;
            obs_last_keep = '0;
            f = make_frame(tab[i].len, tab[i].kind);
            void'(model_frame(f));
            send_frame(f);
            drain();
            ok_e += tab[i].d_ok;
            runt_e += tab[i].d_runt;
            filt_e += tab[i].d_filt;
            check($sformatf("vec%0d words", i), obs_words, tab[i].words);
            check($sformatf("vec%0d last tkeep", i), obs_last_keep, tab[i].last_keep);
            check_counters($sformatf("vec%0d", i));
        end
        compare_streams("table");

        // 64-byte frame: the only input stall is the single flush cycle.
        f = make_frame(64, 0);
        tally(model_frame(f));
        lowcnt = 0;
        count_low = 1'b1;
        send_frame(f);
        repeat (6) @(posedge clock);
        #1;
        count_low = 1'b0;
        check("flush tready low cycles", lowcnt, 1);
        drain();
        compare_streams("flush");

        // Second frame's metadata must wait for the first to be accepted.
        m_meta_ready = 1'b0;
        fa = make_frame(30, 0);
        fb = make_frame(30, 1);
        tally(model_frame(fa));
        tally(model_frame(fb));
        done = 1'b0;
        fork
            begin
                send_frame(fa);
                send_frame(fb);
                done = 1'b1;
            end
        join_none
        repeat (30) @(posedge clock);
        #1;
        check("meta stall s_axis_tready", s_axis_tready, 0);
        check("meta stall m_meta_valid", m_meta_valid, 1);
        check("meta stall m_meta_src", m_meta_src, exp_meta[0].src);
        check("meta stall m_meta_type", m_meta_type, exp_meta[0].typ);
        check("meta stall frames out", got_lens.size(), 1);
        m_meta_ready = 1'b1;
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (!done) bound_fail("meta stall release");
        drain();
        compare_streams("meta stall");
        check_counters("meta stall");

        // Back-to-back random frames with random backpressure on both handshakes.
        rnd = 1'b1;
        for (int i = 0; i < 100; i++) begin
            n = $urandom_range(0, 9);
            f = make_frame($urandom_range(8, 80), (n < 7) ? 0 : (n == 7) ? 1 : 2);
            tally(model_frame(f));
            send_frame(f);
        end
        drain();
        rnd = 1'b0;
        @(posedge clock);
        #1;
        m_axis_tready = 1'b1;
        m_meta_ready = 1'b1;
        drain();
        compare_streams("random");
        check_counters("random");

        // Reset in the middle of a payload, then a clean frame.
        f = make_frame(60, 0);
        for (int w = 0; w < 3; w++) begin
            word_of(f, w, d, k);
            send_word(d, k, 1'b0);
        end
        m_axis_tready = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midreset m_axis_tvalid", m_axis_tvalid, 0);
        check("midreset m_axis_tdata", m_axis_tdata, 0);
        check("midreset m_meta_valid", m_meta_valid, 0);
        reset = 1'b0;
        m_axis_tready = 1'b1;
        clear_queues();
        ok_e = 0;
        runt_e = 0;
        filt_e = 0;
        check_counters("midreset");
        f = make_frame(45, 0);
        tally(model_frame(f));
        send_frame(f);
        drain();
        compare_streams("post reset");
        check_counters("post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
